booth_mult16: RTL and testbench

- Sequential signed radix-2 Booth multiplier.
- Multiplies two WIDTH-bit two's-complement operands and produces a 2*WIDTH-bit signed product.
- Internally an FSM sequences a register datapath: M (multiplicand), Q (multiplier), A (accumulator), Qm (Q[-1] bit) and an iteration counter.
- Standalone arithmetic unit, driven by a start/done handshake.

---
 rtl/booth_mult16_pkg.sv | 18 +
 rtl/booth_mult16_dp.sv | 55 +++++
 rtl/booth_mult16.sv | 65 ++++++
 tb/tb_booth_mult16.sv | 129 ++++++++++++
 4 files changed

// File: rtl/booth_mult16_pkg.sv
// Shared types and constants for the sequential radix-2 Booth multiplier.
package booth_mult16_pkg;
    localparam int WIDTH_DEF = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        ALU   = 3'd2,
        SHIFT = 3'd3,
        DONE  = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        OP_NOP = 2'd0,
        OP_ADD = 2'd1,
        OP_SUB = 2'd2
    } alu_op_t;
endpackage

// File: rtl/booth_mult16_dp.sv
// Booth datapath: M/Q/A/Qm registers, add/sub unit, arithmetic shifter and iteration counter.
module booth_mult16_dp
    import booth_mult16_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  alu_op_t            op,
    input  logic               shift,
    input  logic [WIDTH-1:0]   inp1,
    input  logic [WIDTH-1:0]   inp2,
    output logic [2*WIDTH-1:0] out,
    output logic [1:0]         booth_bits,
    output logic               last
);
    localparam int CW = $clog2(WIDTH) + 1;

    logic [WIDTH:0]   a, m;
    logic [WIDTH-1:0] q;
    logic             qm;
    logic [CW-1:0]    count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a     <= '0;
            m     <= '0;
            q     <= '0;
            qm    <= 1'b0;
            count <= '0;
        end else if (load) begin
            m     <= {inp1[WIDTH-1], inp1};
            q     <= inp2;
            a     <= '0;
            qm    <= 1'b0;
            count <= CW'(WIDTH);
        end else if (op == OP_ADD) begin
            a <= a + m;
        end else if (op == OP_SUB) begin
            a <= a - m;
        end else if (shift) begin
            // {A,Q,Qm} >>> 1 with A's sign bit replicated
            a     <= {a[WIDTH], a[WIDTH:1]};
            q     <= {a[0], q[WIDTH-1:1]};
            qm    <= q[0];
            count <= count - 1'b1;
        end
    end

    assign out        = {a[WIDTH-1:0], q};
    assign booth_bits = {q[0], qm};
    // Count reaches zero on this shift.
    assign last       = (count == CW'(1));
endmodule

// File: rtl/booth_mult16.sv
// Sequential signed Booth multiplier: FSM sequencing the datapath with a start/done handshake.
module booth_mult16
    import booth_mult16_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   inp1,
    input  logic [WIDTH-1:0]   inp2,
    output logic [2*WIDTH-1:0] out,
    output logic               done,
    output logic               busy
);
    state_t     state, state_nxt;
    alu_op_t    op;
    logic       load, shift, last;
    logic [1:0] booth_bits;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = LOAD;
            LOAD:    state_nxt = ALU;
            ALU:     state_nxt = SHIFT;
            SHIFT:   state_nxt = last ? DONE : ALU;
            DONE:    if (start) state_nxt = LOAD;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        load  = (state == LOAD);
        shift = (state == SHIFT);
        done  = (state == DONE);
        busy  = (state == LOAD) || (state == ALU) || (state == SHIFT);
        op    = OP_NOP;
        if (state == ALU) begin
            case (booth_bits)
                2'b10:   op = OP_SUB;
                2'b01:   op = OP_ADD;
                default: op = OP_NOP;
            endcase
        end
    end

    booth_mult16_dp #(.WIDTH(WIDTH)) u_dp (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .op         (op),
        .shift      (shift),
        .inp1       (inp1),
        .inp2       (inp2),
        .out        (out),
        .booth_bits (booth_bits),
        .last       (last)
    );
endmodule

// File: tb/tb_booth_mult16.sv
// Randomized self-checking bench for booth_mult16 against a plain signed-multiply reference.
module tb_booth_mult16;
    localparam int W = 16;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           start = 1'b0;
    logic [W-1:0]   inp1 = '0;
    logic [W-1:0]   inp2 = '0;
    logic [2*W-1:0] out;
    logic           done, busy;

    int checks = 0;
    int errors = 0;

    booth_mult16 #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .inp1  (inp1),
        .inp2  (inp2),
        .out   (out),
        .done  (done),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        return p[2*W-1:0];
    endfunction

    // One multiplication from IDLE/DONE. hold = extra cycles start stays high,
    // scramble = rewrite operands after the LOAD edge, full = emit per-run detail checks.
    task automatic run(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input int hold, input bit scramble, input bit full);
        logic [2*W-1:0] exp;
        int  n;
        bit  bad_ctl;
        exp = ref_mul(a, b);
        @(negedge clk);
        inp1  = a;
        inp2  = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        if (hold == 0) start = 1'b0;
        n = 0;
        bad_ctl = 0;
        while (1) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 1 && scramble) begin
                inp1 = W'($urandom);
                inp2 = W'($urandom);
            end
            if (n >= hold) start = 1'b0;
            if (done || n > 100) break;
            if (!busy) bad_ctl = 1;
        end
        chk({tag, "_lat"}, 64'(n), 64'd33);
        chk({tag, "_out"}, 64'(out), 64'(exp));
        if (full) begin
            chk({tag, "_ctl"}, 64'(bad_ctl), 64'd0);
            chk({tag, "_busy_done"}, 64'(busy), 64'd0);
            repeat (3) @(posedge clk);
            #1;
            chk({tag, "_held"}, 64'({done, out}), 64'({1'b1, exp}));
        end else if (bad_ctl) begin
            chk({tag, "_ctl"}, 64'(bad_ctl), 64'd0);
        end
    endtask

    initial begin
        rst = 1'b1;
        #12;
        chk("rst_out", 64'(out), 64'd0);
        chk("rst_flags", 64'({done, busy}), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        run("basic", 16'd10, 16'd20, 0, 0, 1);
        run("neg_pos", -16'sd7, 16'd13, 0, 0, 1);
        run("neg_neg", -16'sd7, -16'sd13, 0, 0, 0);
        run("zero", 16'd0, 16'h8000, 0, 0, 0);
        run("min_min", 16'h8000, 16'h8000, 0, 0, 1);
        run("min_max", 16'h8000, 16'h7fff, 0, 0, 0);
        run("max_max", 16'h7fff, 16'h7fff, 0, 0, 0);
        run("hold", 16'd10, 16'd20, 5, 0, 1);
        run("restart", 16'd3, -16'sd5, 0, 0, 1);
        run("scramble", 16'd1234, -16'sd77, 0, 1, 1);

        // asynchronous reset mid-operation
        @(negedge clk);
        inp1  = 16'd300;
        inp2  = 16'd400;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("midrst_out", 64'(out), 64'd0);
        chk("midrst_flags", 64'({done, busy}), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_idle", 64'({done, busy}), 64'd0);
        run("after_rst", -16'sd300, 16'd400, 0, 0, 1);

        for (int i = 0; i < 1000; i++)
            run("rand", W'($urandom), W'($urandom), 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
